// File: rtl/lane_ser_pkg.sv
// Shared types, defaults and index helpers for the lane serializer.
// Optional out_last port is controlled by LANE_SERIALIZER_LAST_EN in lane_serializer.sv.
package lane_ser_pkg;

    localparam int unsigned LANE_W_DEF = 8;
    localparam int unsigned LANES_DEF  = 16;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    // Only reachable when LANES is not a power of two.
    function automatic int unsigned clamp_first(input int unsigned first,
                                                input int unsigned lanes);
        return (first >= lanes) ? 0 : first;
    endfunction

    function automatic int unsigned sat_count(input int unsigned count,
                                              input int unsigned lanes);
        return (count >= lanes) ? lanes - 1 : count;
    endfunction

endpackage

// File: rtl/lane_select.sv
// Combinational LANES-to-1 mux of LANE_W-bit lanes; out-of-range select yields 0.
module lane_select #(
    parameter int unsigned LANE_W = 8,
    parameter int unsigned LANES  = 16,
    localparam int unsigned SEL_W = $clog2(LANES)
) (
    input  logic [LANES*LANE_W-1:0] data,
    input  logic [SEL_W-1:0]        sel,
    output logic [LANE_W-1:0]       lane
);

    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (sel == SEL_W'(k)) begin
                lane = data[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures a LANES x LANE_W word and emits a run of lanes with modulo wrap, one per beat.
// Define LANE_SERIALIZER_LAST_EN to add the out_last port marking the final lane of a run.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int unsigned LANE_W = LANE_W_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    localparam int unsigned SEL_W = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [SEL_W-1:0]        in_first,
    input  logic [SEL_W-1:0]        in_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANE_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    busy
`ifdef LANE_SERIALIZER_LAST_EN
    ,
    output logic                    out_last
`endif
);

    state_e                  state_q, state_d;
    logic [LANES*LANE_W-1:0] buffer_q, buffer_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [SEL_W-1:0]        rem_q, rem_d;
    logic [LANE_W-1:0]       lane;
    logic                    sending;
    logic                    last;
    logic                    load;

    assign sending = (state_q == StSend);
    assign last    = sending && (rem_q == '0);
    // out_ready reaches in_ready combinationally so a new word can land on the final beat.
    assign in_ready = !sending || (out_ready && rem_q == '0);
    assign load     = in_valid && in_ready;

    lane_select #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_lane_select (
        .data (buffer_q),
        .sel  (idx_q),
        .lane (lane)
    );

    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d  = StSend;
                    buffer_d = in_data;
                    idx_d    = SEL_W'(clamp_first(32'(in_first), LANES));
                    rem_d    = SEL_W'(sat_count(32'(in_count), LANES));
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - SEL_W'(1);
                        idx_d = (idx_q == SEL_W'(LANES - 1)) ? '0 : idx_q + SEL_W'(1);
                    end else if (load) begin
                        buffer_d = in_data;
                        idx_d    = SEL_W'(clamp_first(32'(in_first), LANES));
                        rem_d    = SEL_W'(sat_count(32'(in_count), LANES));
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            buffer_q <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        out_valid = sending;
        busy      = sending;
        out_data  = sending ? lane : '0;
        out_idx   = sending ? idx_q : '0;
    end

`ifdef LANE_SERIALIZER_LAST_EN
    assign out_last = last;
`else
    logic unused_last;
    assign unused_last = last;
`endif

endmodule
